// File: rtl/gb_timer.sv
// gb_timer: DIV/TIMA/TMA/TAC timer at FF04..FF07; clk/reset, CPU bus (addr_i, data_i, write_i), data_o/sel_o read path, irq_timer_o pulse
module gb_timer #(
  parameter logic [13:0] SYS_CNT_RESET = 14'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        write_i,
  output logic [7:0]  data_o,
  output logic        sel_o,
  output logic        irq_timer_o
);
  typedef enum logic [1:0] {COUNT, OVF, RELOAD} state_t;
  state_t state, state_nxt;
  logic [13:0] cnt, cnt_nxt;
  logic [7:0] tima, tima_nxt, tma, tma_nxt;
  logic [2:0] tac, tac_nxt;
  logic tick_q, tick_nxt, sel_bit, fall, wr, wr_div, wr_tima, wr_tma, wr_tac;
  assign sel_o = addr_i[15:2] == 14'h3FC1;
  assign wr = write_i & sel_o;
  assign wr_div = wr & (addr_i[1:0] == 2'd0);
  assign wr_tima = wr & (addr_i[1:0] == 2'd1);
  assign wr_tma = wr & (addr_i[1:0] == 2'd2);
  assign wr_tac = wr & (addr_i[1:0] == 2'd3);
  assign irq_timer_o = (state == RELOAD) & ~reset;
  always_comb begin
    data_o = !sel_o ? 8'hFF :
             addr_i[1:0] == 2'd0 ? cnt[13:6] :
             addr_i[1:0] == 2'd1 ? tima :
             addr_i[1:0] == 2'd2 ? tma : {5'b11111, tac};
  end
  // Tick is evaluated on the post-edge counter/TAC so that a DIV or TAC
  // write pulling it low increments TIMA on that very edge.
  always_comb begin
    cnt_nxt = wr_div ? 14'd0 : cnt + 14'd1;
    tma_nxt = wr_tma ? data_i : tma;
    tac_nxt = wr_tac ? data_i[2:0] : tac;
    sel_bit = tac_nxt[1] ? (tac_nxt[0] ? cnt_nxt[5] : cnt_nxt[3])
                         : (tac_nxt[0] ? cnt_nxt[1] : cnt_nxt[7]);
    tick_nxt = tac_nxt[2] & sel_bit;
    fall = tick_q & ~tick_nxt;
  end
  always_comb begin
    state_nxt = state;
    tima_nxt = tima;
    case (state)
      COUNT: begin
        if (wr_tima) tima_nxt = data_i;
        else if (fall) begin
          tima_nxt = tima + 8'd1;
          state_nxt = tima == 8'hFF ? OVF : COUNT;
        end
      end
      OVF: begin
        tima_nxt = wr_tima ? data_i : tma_nxt;
        state_nxt = wr_tima ? COUNT : RELOAD;
      end
      RELOAD: begin
        tima_nxt = tma_nxt;
        state_nxt = COUNT;
      end
      default: state_nxt = COUNT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= SYS_CNT_RESET;
      tima <= 8'h00;
      tma <= 8'h00;
      tac <= 3'b000;
      tick_q <= 1'b0;
      state <= COUNT;
    end else begin
      cnt <= cnt_nxt;
      tima <= tima_nxt;
      tma <= tma_nxt;
      tac <= tac_nxt;
      tick_q <= tick_nxt;
      state <= state_nxt;
    end
  end
endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: table vectors, directed timer corner cases and random traffic against a reference model
module tb_gb_timer;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] addr_i;
  logic [7:0] data_i, data_o;
  logic write_i, sel_o, irq_timer_o;
  int n_chk = 0, n_pass = 0;
  int m_cnt, m_pend;
  logic [7:0] m_tima, m_tma;
  logic [2:0] m_tac;
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [7:0]  ed;
    logic        es;
  } vec_t;
  vec_t tbl[12];

  gb_timer dut (
    .clk(clk), .reset(reset), .addr_i(addr_i), .data_i(data_i), .write_i(write_i),
    .data_o(data_o), .sel_o(sel_o), .irq_timer_o(irq_timer_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", n, act, exp);
  endtask

  function automatic bit mtick(input int c, input logic [2:0] t);
    int b;
    b = (t[1:0] == 2'd0) ? 7 : (t[1:0] == 2'd1) ? 1 : (t[1:0] == 2'd2) ? 3 : 5;
    return t[2] && ((c >> b) & 1);
  endfunction

  function automatic logic [7:0] mread(input logic [15:0] a);
    case (a)
      16'hFF04: return 8'((m_cnt >> 6) & 8'hFF);
      16'hFF05: return m_tima;
      16'hFF06: return m_tma;
      16'hFF07: return {5'b11111, m_tac};
      default:  return 8'hFF;
    endcase
  endfunction

  task automatic m_step(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
    int ncnt;
    logic [7:0] ntma;
    logic [2:0] ntac;
    bit wt, fell;
    if (r) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pend = 0;
      return;
    end
    ncnt = (w && a == 16'hFF04) ? 0 : (m_cnt + 1) % 16384;
    ntma = (w && a == 16'hFF06) ? d : m_tma;
    ntac = (w && a == 16'hFF07) ? d[2:0] : m_tac;
    wt = w && a == 16'hFF05;
    fell = mtick(m_cnt, m_tac) && !mtick(ncnt, ntac);
    if (m_pend == 0) begin
      if (wt) m_tima = d;
      else if (fell) begin
        if (m_tima == 8'hFF) begin m_tima = 0; m_pend = 1; end
        else m_tima = m_tima + 1;
      end
    end else if (m_pend == 1) begin
      if (wt) begin m_tima = d; m_pend = 0; end
      else begin m_tima = ntma; m_pend = 2; end
    end else begin
      m_tima = ntma; m_pend = 0;
    end
    m_cnt = ncnt; m_tma = ntma; m_tac = ntac;
  endtask

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
    addr_i = a; data_i = d; write_i = w; reset = r;
    #1;
    chk("data_o", data_o, mread(a));
    chk("sel_o", {7'b0, sel_o}, {7'b0, a[15:2] == 14'h3FC1});
    chk("irq", {7'b0, irq_timer_o}, {7'b0, m_pend == 2 && !r});
    @(posedge clk);
    m_step(a, d, w, r);
    @(negedge clk);
  endtask

  task automatic peek(input string n, input logic [7:0] et, input logic ei, input logic r);
    addr_i = 16'hFF05; data_i = 8'h00; write_i = 1'b0; reset = r;
    #1;
    chk(n, data_o, et);
    chk({n, "_irq"}, {7'b0, irq_timer_o}, {7'b0, ei});
  endtask

  task automatic setup(input logic [2:0] t, input logic [7:0] ti, input logic [7:0] tm);
    cyc(16'hFF05, 8'h00, 1'b0, 1'b1);
    cyc(16'hFF07, {5'b0, t}, 1'b1, 1'b0);
    cyc(16'hFF06, tm, 1'b1, 1'b0);
    cyc(16'hFF05, ti, 1'b1, 1'b0);
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < 1200 && m_pend != p; i++) cyc(16'hFF05, 8'h00, 1'b0, 1'b0);
    if (m_pend != p) begin
      n_chk++;
      $display("FAIL run_until: state %0d not reached, required %0d", m_pend, p);
    end
  endtask

  initial begin
    int irqs;
    logic [7:0] pre;
    tbl[0]  = '{16'hFF08, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[1]  = '{16'h0000, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[2]  = '{16'hFF06, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[3]  = '{16'hFF06, 8'h00, 1'b0, 8'h5A, 1'b1};
    tbl[4]  = '{16'hFF07, 8'h06, 1'b1, 8'hF8, 1'b1};
    tbl[5]  = '{16'hFF07, 8'h00, 1'b0, 8'hFE, 1'b1};
    tbl[6]  = '{16'hFF05, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[7]  = '{16'hFF03, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[8]  = '{16'hFF04, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[9]  = '{16'hFF07, 8'h00, 1'b1, 8'hFE, 1'b1};
    tbl[10] = '{16'hFF05, 8'h00, 1'b0, 8'h01, 1'b1};
    tbl[11] = '{16'hFF05, 8'h00, 1'b1, 8'h01, 1'b1};
    addr_i = 16'h0; data_i = 8'h0; write_i = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    m_step(16'h0, 8'h0, 1'b0, 1'b1);
    @(negedge clk);
    peek("reset_tima", 8'h00, 1'b0, 1'b1);
    chk("reset_div", mread(16'hFF04), 8'h00);
    // DIV: 64 idle cycles -> 01, full 16384 -> wrap to 00
    cyc(16'h0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) cyc(16'hFF04, 8'h00, 1'b0, 1'b0);
    addr_i = 16'hFF04; #1 chk("div_64", data_o, 8'h01);
    for (int i = 64; i < 16384; i++) cyc(16'hFF04, 8'h00, 1'b0, 1'b0);
    addr_i = 16'hFF04; #1 chk("div_wrap", data_o, 8'h00);
    // table: decode, TAC readback, disabling TAC glitch-increments TIMA
    cyc(16'h0, 8'h0, 1'b0, 1'b1);
    foreach (tbl[i]) begin
      addr_i = tbl[i].a; data_i = tbl[i].d; write_i = tbl[i].w; reset = 1'b0;
      #1;
      chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
      chk($sformatf("tbl%0d_sel", i), {7'b0, sel_o}, {7'b0, tbl[i].es});
      cyc(tbl[i].a, tbl[i].d, tbl[i].w, 1'b0);
    end
    // overflow -> OVF reads 00 -> RELOAD loads TMA with one irq cycle
    setup(3'b101, 8'hFE, 8'h40);
    run_until(1);
    peek("ovf_tima", 8'h00, 1'b0, 1'b0);
    cyc(16'hFF05, 8'h00, 1'b0, 1'b0);
    peek("reload_tima", 8'h40, 1'b1, 1'b0);
    cyc(16'hFF05, 8'h00, 1'b0, 1'b0);
    peek("after_reload", 8'h40, 1'b0, 1'b0);
    // TIMA write during OVF cancels reload and irq
    setup(3'b101, 8'hFE, 8'h40);
    run_until(1);
    cyc(16'hFF05, 8'h10, 1'b1, 1'b0);
    peek("ovf_write", 8'h10, 1'b0, 1'b0);
    irqs = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(16'hFF05, 8'h00, 1'b0, 1'b0);
      irqs += int'(irq_timer_o);
    end
    chk("ovf_write_noirq", 8'(irqs), 8'h00);
    peek("ovf_resume", m_tima, 1'b0, 1'b0);
    // TMA write in RELOAD wins; TIMA write in RELOAD is ignored
    setup(3'b101, 8'hFE, 8'h40);
    run_until(2);
    peek("rl_irq", 8'h40, 1'b1, 1'b0);
    cyc(16'hFF06, 8'h77, 1'b1, 1'b0);
    peek("rl_tma_wr", 8'h77, 1'b0, 1'b0);
    setup(3'b101, 8'hFE, 8'h40);
    run_until(2);
    cyc(16'hFF05, 8'h99, 1'b1, 1'b0);
    peek("rl_tima_wr", 8'h40, 1'b0, 1'b0);
    // DIV write glitch with selected bit high vs low
    setup(3'b101, 8'h20, 8'h00);
    for (int i = 0; i < 8 && ((m_cnt >> 1) & 1) == 0; i++) cyc(16'hFF05, 8'h00, 1'b0, 1'b0);
    pre = m_tima;
    cyc(16'hFF04, 8'h5C, 1'b1, 1'b0);
    peek("div_glitch_hi", pre + 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 8 && ((m_cnt >> 1) & 1) == 1; i++) cyc(16'hFF05, 8'h00, 1'b0, 1'b0);
    pre = m_tima;
    cyc(16'hFF04, 8'hA3, 1'b1, 1'b0);
    peek("div_glitch_lo", pre, 1'b0, 1'b0);
    // reset aborts OVF and RELOAD with no irq; writes under reset ignored
    setup(3'b101, 8'hFE, 8'h40);
    run_until(1);
    cyc(16'hFF06, 8'h33, 1'b1, 1'b1);
    peek("rst_ovf", 8'h00, 1'b0, 1'b0);
    chk("rst_write_tma", mread(16'hFF06), 8'h00);
    cyc(16'hFF05, 8'h00, 1'b0, 1'b0);
    peek("rst_ovf_next", 8'h00, 1'b0, 1'b0);
    setup(3'b101, 8'hFE, 8'h40);
    run_until(2);
    peek("rst_reload", 8'h40, 1'b0, 1'b1);
    cyc(16'hFF05, 8'h00, 1'b0, 1'b1);
    peek("rst_reload_next", 8'h00, 1'b0, 1'b0);
    // random bus traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] a;
      int s;
      s = $urandom_range(0, 7);
      a = s < 4 ? 16'hFF04 + 16'(s) : s == 4 ? 16'hFF08 : s == 5 ? 16'hFF03 : 16'($urandom);
      cyc(a, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
